// File: rtl/bicubic_pkg.sv
// Shared constants for the 4x bicubic upsampler: Q11 tap weights, row-phase encoding,
// fixed-point shift and sideband record.
package bicubic_pkg;
  localparam int WGT_W   = 12;
  localparam int SHIFT   = 22;
  localparam int RND_BIT = SHIFT - 1;

  typedef enum logic [1:0] {P0, P1, P2, P3} phase_e;

  typedef struct packed {
    logic sol;
    logic eol;
    logic eof;
  } sband_t;

  // sel: 0..3 = phase 1/8,3/8,5/8,7/8; 5/8 and 7/8 are the mirrored 3/8 and 1/8 sets
  function automatic logic signed [WGT_W-1:0] wgt(input logic [1:0] sel, input logic [1:0] tap);
    logic [2:0] key;
    key = sel[1] ? {~sel[0], ~tap} : {sel[0], tap};
    case (key)
      3'd0:    wgt = -12'sd147;
      3'd1:    wgt =  12'sd1981;
      3'd2:    wgt =  12'sd235;
      3'd3:    wgt = -12'sd21;
      3'd4:    wgt = -12'sd225;
      3'd5:    wgt =  12'sd1535;
      3'd6:    wgt =  12'sd873;
      default: wgt = -12'sd135;
    endcase
  endfunction

  // Output row phase -> vertical weight set
  function automatic logic [1:0] vsel(input phase_e p);
    case (p)
      P0:      vsel = 2'd2;
      P1:      vsel = 2'd3;
      P2:      vsel = 2'd0;
      default: vsel = 2'd1;
    endcase
  endfunction
endpackage

// File: rtl/bicubic_channel_core.sv
// One colour channel: 4x4 window -> 4 horizontal output pixels. Vertical sums, horizontal
// sums, then saturation; stage enables come from the top-level valid chain.
module bicubic_channel_core
  import bicubic_pkg::*;
#(
  parameter int CW     = 8,
  parameter int IPW    = 24,
  parameter int PW     = 32,
  parameter int STAGES = 3,
  parameter int ROUND  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [STAGES-1:0]     i_en,
  input  logic [3:0][WGT_W-1:0] i_wv,
  input  logic [15:0][CW-1:0]   i_pix,
  output logic [3:0][CW-1:0]    o_pix
);
  localparam logic signed [PW:0] RND = (ROUND != 0) ? ((PW+1)'(1) << RND_BIT) : '0;
  localparam logic signed [PW:0] TOP = (PW+1)'(1) << (SHIFT + CW);

  logic signed [IPW-1:0] w_col [4];
  logic signed [IPW-1:0] r_col [4];
  logic signed [PW-1:0]  w_y   [4];
  logic signed [PW-1:0]  r_y   [4];
  logic signed [PW:0]    w_t   [4];
  logic [3:0][CW-1:0]    w_sat;

  // Products are truncated to the accumulator width; two's complement makes signedness moot
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_col[c] = '0;
      for (int r = 0; r < 4; r++)
        w_col[c] = w_col[c] + IPW'($signed(i_wv[r])) * IPW'({1'b0, i_pix[4*r+c]});
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_y[j] = '0;
      for (int c = 0; c < 4; c++)
        w_y[j] = w_y[j] + PW'(wgt(2'(j), 2'(c))) * PW'(r_col[c]);
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_t[j] = (PW+1)'(r_y[j]) + RND;
      if (r_y[j] < 0)        w_sat[j] = '0;
      else if (w_t[j] >= TOP) w_sat[j] = '1;
      else                    w_sat[j] = w_t[j][SHIFT +: CW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_col[i] <= '0;
        r_y[i]   <= '0;
      end
    end else begin
      if (i_en[0]) r_col <= w_col;
      if (i_en[1]) r_y   <= w_y;
    end
  end

  if (STAGES == 2) begin : g_direct
    assign o_pix = w_sat;
  end else begin : g_out
    logic [STAGES-1:2][3:0][CW-1:0] r_out;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_out <= '0;
      else begin
        if (i_en[2]) r_out[2] <= w_sat;
        for (int k = 3; k < STAGES; k++)
          if (i_en[k]) r_out[k] <= r_out[k-1];
      end
    end
    assign o_pix = r_out[STAGES-1];
  end
endmodule

// File: rtl/bicubic_upsample_mc.sv
// Multi-channel 4x bicubic upsampler top: frame counters, row-phase FSM, bubble-collapsing
// valid chain, sideband pipe and cfg latch around CHANNELS channel cores.
module bicubic_upsample_mc
  import bicubic_pkg::*;
#(
  parameter int CHANNEL_WIDTH       = 8,
  parameter int CHANNELS            = 3,
  parameter int INTER_PRODUCT_WIDTH = 24,
  parameter int PRODUCT_WIDTH       = 32,
  parameter int PIPE_STAGES         = 3,
  parameter int MAX_SRC_WIDTH       = 960,
  parameter int MAX_SRC_HEIGHT      = 540,
  parameter int ROUND               = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [$clog2(MAX_SRC_WIDTH):0]        cfg_src_width,
  input  logic [$clog2(MAX_SRC_HEIGHT):0]       cfg_src_height,
  input  logic                                  bf_req_valid,
  output logic                                  bcci_req_ready,
  input  logic [CHANNELS*16*CHANNEL_WIDTH-1:0]  bf_req_pix,
  output logic                                  bcci_rsp_valid,
  input  logic                                  bf_rsp_ready,
  output logic [CHANNELS*4*CHANNEL_WIDTH-1:0]   bcci_rsp_data,
  output logic                                  bcci_rsp_sol,
  output logic                                  bcci_rsp_eol,
  output logic                                  bcci_rsp_eof,
  output logic                                  busy
);
  localparam int WW = $clog2(MAX_SRC_WIDTH) + 1;
  localparam int HW = $clog2(MAX_SRC_HEIGHT) + 1;
  localparam int RW = HW + 2;
  localparam int S  = PIPE_STAGES;
  localparam int CW = CHANNEL_WIDTH;

  logic          r_active;
  logic [WW-1:0] r_w, r_col, w_w;
  logic [HW-1:0] r_h, w_h;
  logic [RW-1:0] r_row, w_last_row;
  phase_e        r_phase, w_phase_nxt;
  logic          w_cfg_ok, w_acc, w_eol, w_eof;
  logic [S-1:0]  r_vld, w_go, w_load, w_vin, w_en;
  sband_t [S-1:0] r_sb;
  sband_t        w_sb_in;
  logic [3:0][WGT_W-1:0] w_wv;

  // Live cfg is only consulted while idle; a running frame uses the latched copy
  assign w_w        = r_active ? r_w : cfg_src_width;
  assign w_h        = r_active ? r_h : cfg_src_height;
  assign w_cfg_ok   = (w_w != '0) && (w_h != '0);
  assign w_last_row = {w_h, 2'b00} - RW'(1);
  assign w_eol      = (r_col == w_w - WW'(1));
  assign w_eof      = w_eol && (r_row == w_last_row);
  assign w_acc      = bf_req_valid && bcci_req_ready;
  assign w_sb_in    = '{sol: (r_col == '0), eol: w_eol, eof: w_eof};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_w      <= '0;
      r_h      <= '0;
      r_col    <= '0;
      r_row    <= '0;
    end else if (w_acc) begin
      if (!r_active) begin
        r_active <= 1'b1;
        r_w      <= cfg_src_width;
        r_h      <= cfg_src_height;
      end
      if (w_eof) begin
        r_active <= 1'b0;
        r_col    <= '0;
        r_row    <= '0;
      end else if (w_eol) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + WW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_phase <= P0;
    else        r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = r_phase;
    if (w_acc && w_eof) w_phase_nxt = P0;
    else if (w_acc && w_eol) begin
      case (r_phase)
        P0:      w_phase_nxt = P1;
        P1:      w_phase_nxt = P2;
        P2:      w_phase_nxt = P3;
        default: w_phase_nxt = P0;
      endcase
    end
  end

  // Stage k may hand off when the sink is ready or any later stage is empty
  for (genvar k = 0; k < S; k++) begin : g_go
    if (k == S-1) begin : g_last
      assign w_go[k] = bf_rsp_ready;
    end else begin : g_mid
      assign w_go[k] = bf_rsp_ready | ~(&r_vld[S-1:k+1]);
    end
  end

  assign w_load         = ~r_vld | w_go;
  assign w_vin          = {r_vld[S-2:0], w_acc};
  assign w_en           = w_load & w_vin;
  assign bcci_req_ready = w_load[0] & w_cfg_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_sb  <= '0;
    end else begin
      for (int k = 0; k < S; k++)
        if (w_load[k]) r_vld[k] <= w_vin[k];
      if (w_en[0]) r_sb[0] <= w_sb_in;
      for (int k = 1; k < S; k++)
        if (w_en[k]) r_sb[k] <= r_sb[k-1];
    end
  end

  always_comb begin
    for (int r = 0; r < 4; r++) w_wv[r] = wgt(vsel(r_phase), 2'(r));
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    bicubic_channel_core #(
      .CW(CW), .IPW(INTER_PRODUCT_WIDTH), .PW(PRODUCT_WIDTH), .STAGES(S), .ROUND(ROUND)
    ) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_en),
      .i_wv  (w_wv),
      .i_pix (bf_req_pix[ch*16*CW +: 16*CW]),
      .o_pix (bcci_rsp_data[ch*4*CW +: 4*CW])
    );
  end

  assign bcci_rsp_valid = r_vld[S-1];
  assign bcci_rsp_sol   = r_sb[S-1].sol;
  assign bcci_rsp_eol   = r_sb[S-1].eol;
  assign bcci_rsp_eof   = r_sb[S-1].eof;
  assign busy           = r_active | (|r_vld);
endmodule

// File: tb/tb_bicubic_upsample_mc.sv
// Bench for bicubic_upsample_mc: constant vector table, streamed frames checked against an
// integer reference model through a scoreboard queue, backpressure and mid-frame reset sequences.
module tb_bicubic_upsample_mc;
  localparam int CW = 8, CH = 3, S = 3, MW = 960, MH = 540;
  localparam int PIXW = CH*16*CW, OUTW = CH*4*CW;
  localparam int WW = $clog2(MW) + 1, HW = $clog2(MH) + 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [WW-1:0] cfg_w = '0;
  logic [HW-1:0] cfg_h = '0;
  logic req_valid = 1'b0, req_ready;
  logic [PIXW-1:0] req_pix = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [OUTW-1:0] rsp_data;
  logic sol, eol, eof, busy;

  always #5 clk = ~clk;

  bicubic_upsample_mc #(
    .CHANNEL_WIDTH(CW), .CHANNELS(CH), .INTER_PRODUCT_WIDTH(24), .PRODUCT_WIDTH(32),
    .PIPE_STAGES(S), .MAX_SRC_WIDTH(MW), .MAX_SRC_HEIGHT(MH), .ROUND(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_src_width(cfg_w), .cfg_src_height(cfg_h),
    .bf_req_valid(req_valid), .bcci_req_ready(req_ready), .bf_req_pix(req_pix),
    .bcci_rsp_valid(rsp_valid), .bf_rsp_ready(rsp_ready), .bcci_rsp_data(rsp_data),
    .bcci_rsp_sol(sol), .bcci_rsp_eol(eol), .bcci_rsp_eof(eof), .busy(busy)
  );

  typedef struct packed {
    logic [OUTW-1:0] data;
    logic sol;
    logic eol;
    logic eof;
  } exp_t;

  typedef struct packed {
    logic [3:0][7:0] rows;
    logic [7:0]      expv;
  } tvec_t;

  exp_t q[$];
  int n_vec = 0, n_err = 0, stalls = 0, rdy_mode = 0;

  // Weight sets at horizontal phases 1/8, 3/8, 5/8, 7/8; row phase P0..P3 uses 5/8,7/8,1/8,3/8
  int WT [0:3][0:3] = '{'{-147, 1981, 235, -21}, '{-225, 1535, 873, -135},
                        '{-135, 873, 1535, -225}, '{-21, 235, 1981, -147}};
  int VMAP [0:3] = '{2, 3, 0, 1};

  function automatic logic [OUTW-1:0] model(input logic [PIXW-1:0] pix, input int ph);
    logic [OUTW-1:0] o;
    longint col [4];
    longint y, v;
    o = '0;
    for (int ch = 0; ch < CH; ch++) begin
      for (int c = 0; c < 4; c++) begin
        col[c] = 0;
        for (int r = 0; r < 4; r++)
          col[c] += WT[VMAP[ph]][r] * longint'(pix[(ch*16 + 4*r + c)*CW +: CW]);
      end
      for (int j = 0; j < 4; j++) begin
        y = 0;
        for (int c = 0; c < 4; c++) y += WT[j][c] * col[c];
        if (y < 0) v = 0;
        else begin
          v = (y + 2097152) / 4194304;
          if (v > 255) v = 255;
        end
        o[(ch*4 + j)*CW +: CW] = 8'(v);
      end
    end
    return o;
  endfunction

  function automatic exp_t mk_exp(input logic [PIXW-1:0] pix, input int n, input int W, input int H);
    exp_t e;
    e.data = model(pix, (n / W) % 4);
    e.sol  = (n % W) == 0;
    e.eol  = (n % W) == W - 1;
    e.eof  = n == 4*W*H - 1;
    return e;
  endfunction

  function automatic logic [PIXW-1:0] rand_pix();
    logic [PIXW-1:0] p;
    for (int i = 0; i < PIXW/32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic logic [PIXW-1:0] rows_pix(input logic [3:0][7:0] rows);
    logic [PIXW-1:0] p;
    for (int ch = 0; ch < CH; ch++)
      for (int i = 0; i < 16; i++) p[(ch*16 + i)*CW +: CW] = rows[i/4];
    return p;
  endfunction

  function automatic tvec_t mk_tv(input int r0, input int r1, input int r2, input int r3, input int e);
    tvec_t t;
    t.rows[0] = 8'(r0); t.rows[1] = 8'(r1); t.rows[2] = 8'(r2); t.rows[3] = 8'(r3);
    t.expv = 8'(e);
    return t;
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic send(input logic [PIXW-1:0] pix, input exp_t e, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    req_valid = 1'b1;
    req_pix   = pix;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (req_ready) begin
        q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        return;
      end
      stalls++;
      @(posedge clk); #1;
    end
    n_vec++; n_err++;
    $display("FAIL send_timeout: req_ready stayed 0 for 5000 cycles, required 1");
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || busy) && t < 2000) begin @(posedge clk); #1; t++; end
    chk("drain_empty_idle", (q.size() == 0 && !busy), 1);
  endtask

  task automatic run_frame(input int W, input int H, input bit rnd, input bit gaps, input bit jitter);
    logic [PIXW-1:0] p;
    cfg_w = WW'(W);
    cfg_h = HW'(H);
    for (int n = 0; n < 4*W*H; n++) begin
      p = rnd ? rand_pix() : {(PIXW/8){8'd100}};
      send(p, mk_exp(p, n, W, H), gaps);
      if (jitter) begin
        cfg_w = WW'($urandom_range(0, 900));
        cfg_h = HW'($urandom_range(0, 500));
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom_range(0, 2) != 0);
      default: rsp_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got data %h with no beat outstanding", rsp_data);
      end else begin
        e = q.pop_front();
        if (rsp_data !== e.data) begin
          n_err++;
          $display("FAIL data: got %h required %h", rsp_data, e.data);
        end
        n_vec++;
        if ({sol, eol, eof} !== {e.sol, e.eol, e.eof}) begin
          n_err++;
          $display("FAIL sideband sol/eol/eof: got %b required %b", {sol, eol, eof}, {e.sol, e.eol, e.eof});
        end
      end
    end
  end

  initial begin
    tvec_t tv [8];
    exp_t e;
    logic [PIXW-1:0] p;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_data_zero", (rsp_data == '0), 1);
    chk("rst_flags", {sol, eol, eof}, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Zero-sized frame: nothing may be accepted and the block stays idle
    req_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("zero_cfg_req_ready", req_ready, 0);
    chk("zero_cfg_busy", busy, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;

    // Vector table, W=1 H=2 so entry i lands on row phase i%4
    tv[0] = mk_tv(100, 100, 100, 100, 100);
    tv[1] = mk_tv(255, 255, 255, 255, 255);
    tv[2] = mk_tv(0, 0, 255, 0, 29);
    tv[3] = mk_tv(0, 0, 0, 0, 0);
    tv[4] = mk_tv(255, 0, 0, 255, 0);
    tv[5] = mk_tv(100, 100, 100, 100, 100);
    tv[6] = mk_tv(0, 255, 255, 0, 255);
    tv[7] = mk_tv(255, 255, 255, 255, 255);
    rdy_mode = 0;
    cfg_w = WW'(1);
    cfg_h = HW'(2);
    for (int i = 0; i < 8; i++) begin
      e.data = {(OUTW/8){tv[i].expv}};
      e.sol  = 1'b1;
      e.eol  = 1'b1;
      e.eof  = (i == 7);
      send(rows_pix(tv[i].rows), e, 1'b0);
    end
    drain();

    // Flat 100 across every phase
    run_frame(3, 1, 1'b0, 1'b0, 1'b0);
    drain();

    // Continuous W=4 H=2: one beat per cycle, busy falls after the last
    stalls = 0;
    run_frame(4, 2, 1'b1, 1'b0, 1'b0);
    chk("continuous_stalls", stalls, 0);
    drain();

    // Output stalled for 10 cycles under continuous input
    rdy_mode  = 2;
    rsp_ready = 1'b0;
    cfg_w = WW'(4);
    cfg_h = HW'(1);
    n = 0;
    p = rand_pix();
    req_valid = 1'b1;
    req_pix   = p;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready) begin
        q.push_back(mk_exp(p, n, 4, 1));
        n++;
        p = rand_pix();
      end
      @(posedge clk); #1;
      req_pix = p;
    end
    @(negedge clk);
    chk("bp_absorbed", n, S);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_rsp_valid_held", rsp_valid, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rdy_mode  = 0;
    rsp_ready = 1'b1;
    for (int k = n; k < 16; k++) begin
      p = rand_pix();
      send(p, mk_exp(p, k, 4, 1), 1'b0);
    end
    drain();

    // Random valid gaps and random ready; second frame scrambles cfg mid-frame
    rdy_mode = 1;
    run_frame(3, 2, 1'b1, 1'b1, 1'b0);
    run_frame(5, 1, 1'b1, 1'b1, 1'b1);
    drain();
    rdy_mode = 0;

    // Reset at beat 17 of a 32-beat frame, then a clean restart
    cfg_w = WW'(4);
    cfg_h = HW'(2);
    for (int k = 0; k < 17; k++) begin
      p = rand_pix();
      send(p, mk_exp(p, k, 4, 2), 1'b0);
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_data_zero", (rsp_data == '0), 1);
    chk("midrst_flags", {sol, eol, eof}, 0);
    chk("midrst_busy", busy, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(2, 1, 1'b1, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
